// File: rtl/conv_pkg.sv
// Shared definitions for the convolution front end: the opaque tag layout.
package conv_pkg;

  localparam int OPAQUE_NEW_BIT   = 7;
  localparam int OPAQUE_IDX_WIDTH = 7;

  typedef logic [7:0] opaque_t;

endpackage

// File: rtl/conv_frame_bank.sv
// One frame register: FRAME_PIX pixel slots, one slot written per cycle,
// the whole frame visible on a flat bus in conv-core layout.
module conv_frame_bank #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_PIX  = 128,
  parameter int IDX_WIDTH  = 7
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_en,
  input  logic [IDX_WIDTH-1:0]            wr_idx,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  output logic [FRAME_PIX*DATA_WIDTH-1:0] frame_out
);

  for (genvar g = 0; g < FRAME_PIX; g++) begin : g_slot
    logic [DATA_WIDTH-1:0] r_pix;
    logic                  w_hit;

    assign w_hit = wr_en && (wr_idx == IDX_WIDTH'(g));

    // Capture the pixel when this slot is addressed; cleared on reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_pix <= '0;
      end else if (w_hit) begin
        r_pix <= wr_data;
      end
    end

    assign frame_out[g*DATA_WIDTH +: DATA_WIDTH] = r_pix;
  end

endmodule

// File: rtl/conv_img_loader.sv
// Serial pixel stream to ping-pong frame buffer feeding the conv core.
// One bank fills while the other is presented; a completed frame swaps in
// one cycle after its final beat, held at least MIN_HOLD cycles.
module conv_img_loader
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int IMG_D      = 2,
  parameter int MIN_HOLD   = 4,
  localparam int FRAME_PIX  = IMG_D * IMG_H * IMG_W,
  localparam int CNT_WIDTH  = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1,
  localparam int HOLD_WIDTH = $clog2(MIN_HOLD + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DATA_WIDTH-1:0]           pix_in,
  input  logic                            pix_valid,
  input  logic                            pix_last,
  output logic                            pix_ready,
  output logic [FRAME_PIX*DATA_WIDTH-1:0] img_data_out,
  output opaque_t                         opaque_out,
  output logic                            frame_err
);

  logic [CNT_WIDTH-1:0]        r_wr_cnt;
  logic                        r_wr_sel;
  logic [OPAQUE_IDX_WIDTH-1:0] r_frame_idx;
  logic [HOLD_WIDTH-1:0]       r_hold_cnt;
  opaque_t                     r_opaque;
  logic                        r_frame_err;

  logic                            w_last_slot;
  logic                            w_accept;
  logic [FRAME_PIX*DATA_WIDTH-1:0] w_bank0_frame;
  logic [FRAME_PIX*DATA_WIDTH-1:0] w_bank1_frame;

  // Only the final beat stalls: the swap it triggers must wait out the hold.
  assign w_last_slot = (r_wr_cnt == CNT_WIDTH'(FRAME_PIX - 1));
  assign pix_ready   = !(w_last_slot && (r_hold_cnt != '0));
  assign w_accept    = pix_valid && pix_ready;

  // r_wr_sel names the fill bank; the other one is presented and never written.
  conv_frame_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAME_PIX  (FRAME_PIX),
    .IDX_WIDTH  (CNT_WIDTH)
  ) u_bank0 (
    .clk       (clk),
    .rst_n     (reset),
    .wr_en     (w_accept && !r_wr_sel),
    .wr_idx    (r_wr_cnt),
    .wr_data   (pix_in),
    .frame_out (w_bank0_frame)
  );

  conv_frame_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAME_PIX  (FRAME_PIX),
    .IDX_WIDTH  (CNT_WIDTH)
  ) u_bank1 (
    .clk       (clk),
    .rst_n     (reset),
    .wr_en     (w_accept && r_wr_sel),
    .wr_idx    (r_wr_cnt),
    .wr_data   (pix_in),
    .frame_out (w_bank1_frame)
  );

  // Beat counting, bank swap, hold timer, frame tagging and framing errors.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_cnt    <= '0;
      r_wr_sel    <= 1'b0;
      r_frame_idx <= '0;
      r_hold_cnt  <= '0;
      r_opaque    <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err              <= 1'b0;
      r_opaque[OPAQUE_NEW_BIT] <= 1'b0;
      if (r_hold_cnt != '0) begin
        r_hold_cnt <= r_hold_cnt - HOLD_WIDTH'(1);
      end
      if (w_accept) begin
        if (w_last_slot) begin
          // A full count completes the frame even without pix_last; flag it.
          r_wr_sel    <= ~r_wr_sel;
          r_wr_cnt    <= '0;
          r_hold_cnt  <= HOLD_WIDTH'(MIN_HOLD - 1);
          r_opaque    <= {1'b1, r_frame_idx};
          r_frame_idx <= r_frame_idx + OPAQUE_IDX_WIDTH'(1);
          r_frame_err <= ~pix_last;
        end else if (pix_last) begin
          // Short frame: drop it; the next frame overwrites the partial fill.
          r_wr_cnt    <= '0;
          r_frame_err <= 1'b1;
        end else begin
          r_wr_cnt <= r_wr_cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign img_data_out = r_wr_sel ? w_bank0_frame : w_bank1_frame;
  assign opaque_out   = r_opaque;
  assign frame_err    = r_frame_err;

endmodule

// File: tb/tb_conv_img_loader.sv
// Bench for conv_img_loader: a frame-level model checked every cycle against
// the default-size DUT, literal checks at each frame boundary, and a small
// instance exercising the minimum-hold stall.
module tb_conv_img_loader;

  localparam int FP = 128;
  localparam int MH = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic [7:0]       pix_in = '0;
  logic             pix_valid = 1'b0;
  logic             pix_last = 1'b0;
  wire              pix_ready;
  wire [FP*DW-1:0]  img_data_out;
  wire [7:0]        opaque_out;
  wire              frame_err;

  logic [7:0]       s_pix = '0;
  logic             s_valid = 1'b0;
  logic             s_last = 1'b0;
  wire              s_ready;
  wire [31:0]       s_img;
  wire [7:0]        s_opq;
  wire              s_err;

  always #5 clk = ~clk;

  conv_img_loader dut (
    .clk          (clk),
    .reset        (rst_n),
    .pix_in       (pix_in),
    .pix_valid    (pix_valid),
    .pix_last     (pix_last),
    .pix_ready    (pix_ready),
    .img_data_out (img_data_out),
    .opaque_out   (opaque_out),
    .frame_err    (frame_err)
  );

  conv_img_loader #(
    .DATA_WIDTH (8),
    .IMG_W      (2),
    .IMG_H      (2),
    .IMG_D      (1),
    .MIN_HOLD   (8)
  ) dut_s (
    .clk          (clk),
    .reset        (rst_n),
    .pix_in       (s_pix),
    .pix_valid    (s_valid),
    .pix_last     (s_last),
    .pix_ready    (s_ready),
    .img_data_out (s_img),
    .opaque_out   (s_opq),
    .frame_err    (s_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] val(input int kind, input int n);
    int v;
    case (kind)
      0:       v = n;
      1:       v = 255 - n;
      2:       v = n + 1;
      3:       v = n ^ 90;
      default: v = n * 3;
    endcase
    return v[7:0];
  endfunction

  function automatic int slot_bad(input int kind);
    int bad = 0;
    for (int n = 0; n < FP; n++)
      if (img_data_out[n*DW +: DW] !== val(kind, n)) bad++;
    return bad;
  endfunction

  // ---------------- frame-level model ----------------
  logic [7:0]      m_fill [FP];
  logic [7:0]      m_pres [FP];
  int              m_beats;
  int              m_idx;
  int              m_since;
  logic [7:0]      m_opq;
  logic            m_err;
  logic            m_rdy;
  logic [FP*DW-1:0] m_bus;
  bit              cmp_en = 1'b0;

  function automatic logic m_ready();
    return !(m_beats == FP - 1 && m_since < MH - 1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FP; i++) begin
        m_fill[i] = '0;
        m_pres[i] = '0;
      end
      m_beats = 0;
      m_idx   = 0;
      m_since = MH;
      m_opq   = '0;
      m_err   = 1'b0;
    end else begin
      m_rdy = m_ready();
      if (m_since < MH) m_since++;
      m_err    = 1'b0;
      m_opq[7] = 1'b0;
      if (pix_valid && m_rdy) begin
        m_fill[m_beats] = pix_in;
        if (m_beats == FP - 1) begin
          m_pres  = m_fill;
          m_opq   = {1'b1, 7'(m_idx % 128)};
          m_idx++;
          m_err   = !pix_last;
          m_beats = 0;
          m_since = 0;
        end else if (pix_last) begin
          m_beats = 0;
          m_err   = 1'b1;
        end else begin
          m_beats++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < FP; i++) m_bus[i*DW +: DW] = m_pres[i];
      n_checks++;
      if (img_data_out !== m_bus) begin
        int k;
        k = 0;
        while (k < FP - 1 && img_data_out[k*DW +: DW] === m_bus[k*DW +: DW]) k++;
        n_fail++;
        $display("FAIL cyc_img slot %0d: got %0h expected %0h", k,
                 img_data_out[k*DW +: DW], m_bus[k*DW +: DW]);
      end
      chk("cyc_ready", pix_ready, m_ready());
      chk("cyc_opaque", opaque_out, m_opq);
      chk("cyc_err", frame_err, m_err);
    end
  end

  // ---------------- drivers ----------------
  task automatic beat(input logic [7:0] d, input bit last);
    bit done;
    done = 1'b0;
    pix_in    = d;
    pix_valid = 1'b1;
    pix_last  = last;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      if (pix_ready) done = 1'b1;
      @(posedge clk);
    end
    #1;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL beat_timeout: pix_ready stayed 0, expected 1");
    end
  endtask

  task automatic frame(input int kind, input int nb, input int last_at);
    for (int n = 0; n < nb; n++) beat(val(kind, n), n == last_at);
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  logic [FP*DW-1:0] saved;
  int   bad;
  int   k, sw1, sw2, lowfirst, lowcnt, errseen;
  logic acc;
  logic [31:0] img1, img2;
  logic [7:0]  o1, o2;

  initial begin
    #1 rst_n = 1'b0;
    #2 cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset mid-stream after a frame is already presented
    frame(2, 128, 127);
    chk("pre_opaque", opaque_out, 8'h80);
    chk("pre_slots_bad", slot_bad(2), 0);
    frame(2, 30, -1);
    pix_valid = 1'b1;
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_img_nonzero", |img_data_out, 1'b0);
      chk("rst_opaque", opaque_out, 8'h00);
      chk("rst_err", frame_err, 1'b0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    pix_valid = 1'b0;
    @(negedge clk);
    chk("rst_ready", pix_ready, 1'b1);
    @(posedge clk);
    #1;

    // Frame 0: pix_in = n
    for (int n = 0; n < FP; n++) beat(val(0, n), n == FP - 1);
    chk("f0_opaque", opaque_out, 8'h80);
    chk("f0_slots_bad", slot_bad(0), 0);
    saved = img_data_out;

    // Frame 1 back-to-back: pix_in = 255-n, frame 0 stays presented
    beat(val(1, 0), 1'b0);
    chk("f0_opaque_next", opaque_out, 8'h00);
    bad = 0;
    for (int n = 1; n < FP; n++) begin
      beat(val(1, n), n == FP - 1);
      if (n < FP - 1 && img_data_out !== saved) bad++;
    end
    pix_valid = 1'b0;
    pix_last  = 1'b0;
    chk("f0_held_bad", bad, 0);
    chk("f1_opaque", opaque_out, 8'h81);
    chk("f1_slots_bad", slot_bad(1), 0);
    @(posedge clk);
    #1 chk("f1_opaque_next", opaque_out, 8'h01);

    // Early pix_last on beat 10: discard, no swap
    saved = img_data_out;
    frame(2, 11, 10);
    chk("early_err", frame_err, 1'b1);
    chk("early_opaque", opaque_out, 8'h01);
    chk("early_noswap", img_data_out === saved, 1'b1);
    @(posedge clk);
    #1 chk("early_err_clear", frame_err, 1'b0);
    frame(3, 128, 127);
    chk("f2_opaque", opaque_out, 8'h82);
    chk("f2_err", frame_err, 1'b0);
    chk("f2_slots_bad", slot_bad(3), 0);
    @(posedge clk);
    #1 chk("f2_opaque_next", opaque_out, 8'h02);

    // Missing pix_last: swap anyway with error pulse
    frame(4, 128, -1);
    chk("nolast_opaque", opaque_out, 8'h83);
    chk("nolast_err", frame_err, 1'b1);
    chk("nolast_slots_bad", slot_bad(4), 0);
    @(posedge clk);
    #1;
    chk("nolast_err_clear", frame_err, 1'b0);
    chk("nolast_opaque_next", opaque_out, 8'h03);

    // Small instance: 4-pixel frames, MIN_HOLD=8, valid held high
    k = 0; sw1 = -1; sw2 = -1; lowfirst = -1; lowcnt = 0; errseen = 0;
    img1 = '0; img2 = '0; o1 = '0; o2 = '0;
    for (int c = 0; c < 30; c++) begin
      s_pix   = k[7:0];
      s_last  = (k % 4 == 3);
      s_valid = (k < 8);
      @(negedge clk);
      acc = s_valid && s_ready;
      if (s_valid && !s_ready) begin
        lowcnt++;
        if (lowfirst < 0) lowfirst = c;
      end
      @(posedge clk);
      #1;
      if (acc) k++;
      if (s_err) errseen++;
      if (s_opq[7]) begin
        if (sw1 < 0) begin
          sw1 = c; img1 = s_img; o1 = s_opq;
        end else if (sw2 < 0) begin
          sw2 = c; img2 = s_img; o2 = s_opq;
        end
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    chk("hold_swap1_cycle", sw1, 3);
    chk("hold_swap2_cycle", sw2, 11);
    chk("hold_swap_gap", sw2 - sw1, 8);
    chk("hold_stall_start", lowfirst, 7);
    chk("hold_stall_len", lowcnt, 4);
    chk("hold_img1", img1, 32'h03020100);
    chk("hold_img2", img2, 32'h07060504);
    chk("hold_opq1", o1, 8'h80);
    chk("hold_opq2", o2, 8'h81);
    chk("hold_no_err", errseen, 0);

    repeat (3) @(posedge clk);
    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
